// File: rtl/mem_dbus_stage.sv
// Memory-stage register and data-bus initiator.
// Issues one dreq per load/store and holds the pipe until dresp completes.
module mem_dbus_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] e_pc,
  input  logic [31:0] e_val3,
  input  logic [31:0] e_valt,
  input  logic [5:0]  e_icode,
  input  logic [4:0]  e_dst,
  input  logic        M_stall,
  input  logic        M_bubble,
  output logic [31:0] m_pc,
  output logic [5:0]  m_icode,
  output logic [4:0]  m_dst,
  output logic [31:0] m_valM,
  output logic        m_busy,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data
);

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2b;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t      state;
  logic [31:0] val3_q;
  logic [31:0] valt_q;
  logic [31:0] rdata_q;
  logic        load_en;
  logic        e_mem;

  assign m_busy  = (state != IDLE);
  assign load_en = !(M_stall | m_busy);
  assign e_mem   = e_icode inside {LB, LH, LW, LBU, LHU, SB, SH, SW};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pc    <= '0;
      m_icode <= '0;
      m_dst   <= '0;
      val3_q  <= '0;
      valt_q  <= '0;
      rdata_q <= '0;
      state   <= IDLE;
    end else begin
      if (load_en) begin
        if (M_bubble) begin
          m_pc    <= '0;
          m_icode <= '0;
          m_dst   <= '0;
          val3_q  <= '0;
          valt_q  <= '0;
        end else begin
          m_pc    <= e_pc;
          m_icode <= e_icode;
          m_dst   <= e_dst;
          val3_q  <= e_val3;
          valt_q  <= e_valt;
        end
      end
      unique case (state)
        IDLE: begin
          if (load_en && !M_bubble && e_mem)
            state <= ADDR;
        end
        ADDR: begin
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              rdata_q <= dresp_data;
              state   <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (dresp_data_ok) begin
            rdata_q <= dresp_data;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic        byte_op;
  logic        half_op;
  logic        word_op;
  logic        store_op;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;

  assign byte_op  = m_icode inside {LB, LBU, SB};
  assign half_op  = m_icode inside {LH, LHU, SH};
  assign word_op  = m_icode inside {LW, SW};
  assign store_op = m_icode inside {SB, SH, SW};

  always_comb begin
    req_addr   = '0;
    req_size   = 2'd0;
    req_strobe = 4'b0000;
    req_data   = '0;
    unique case (1'b1)
      byte_op: begin
        req_addr = val3_q;
        req_size = 2'd0;
        if (store_op) begin
          req_strobe = 4'b0001 << val3_q[1:0];
          req_data   = {4{valt_q[7:0]}};
        end
      end
      half_op: begin
        req_addr = {val3_q[31:1], 1'b0};
        req_size = 2'd1;
        if (store_op) begin
          req_strobe = val3_q[1] ? 4'b1100 : 4'b0011;
          req_data   = {2{valt_q[15:0]}};
        end
      end
      word_op: begin
        req_addr = {val3_q[31:2], 2'b00};
        req_size = 2'd2;
        if (store_op) begin
          req_strobe = 4'b1111;
          req_data   = valt_q;
        end
      end
      default: ;
    endcase
  end

  // Request fields read zero outside ADDR so the bus sees a clean idle.
  assign dreq_valid  = (state == ADDR);
  assign dreq_addr   = dreq_valid ? req_addr : '0;
  assign dreq_size   = dreq_valid ? req_size : 2'd0;
  assign dreq_strobe = dreq_valid ? req_strobe : 4'b0000;
  assign dreq_data   = dreq_valid ? req_data : '0;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    unique case (val3_q[1:0])
      2'd0: lane_b = rdata_q[7:0];
      2'd1: lane_b = rdata_q[15:8];
      2'd2: lane_b = rdata_q[23:16];
      2'd3: lane_b = rdata_q[31:24];
      default: lane_b = 8'h00;
    endcase
  end

  assign lane_h = val3_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    m_valM = val3_q;
    unique case (m_icode)
      LB:  m_valM = {{24{lane_b[7]}}, lane_b};
      LBU: m_valM = {24'h0, lane_b};
      LH:  m_valM = {{16{lane_h[15]}}, lane_h};
      LHU: m_valM = {16'h0, lane_h};
      LW:  m_valM = rdata_q;
      default: m_valM = val3_q;
    endcase
  end

endmodule
